// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
//   Shared definitions for the SPI serial-clock engine:
//     - spi_state_e      : frame sequencer states
//     - DEFAULT_HALF_DIV : divisor a system integrator can use when nothing
//                          better is known (slow, safe SCLK)
//     - is_sample_edge() : classifies an SCLK edge as sample or launch
// -----------------------------------------------------------------------------
package spi_pkg;

    // Frame sequencer states.
    //   ST_IDLE     : chip select released, SCLK parked at CPOL
    //   ST_LEAD     : chip select asserted, one tick of setup before SCLK moves
    //   ST_CLOCKING : SCLK toggles once per tick, 2*n_bits edges in total
    //   ST_TRAIL    : SCLK parked again, one tick of hold before release
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LEAD     = 2'd1,
        ST_CLOCKING = 2'd2,
        ST_TRAIL    = 2'd3
    } spi_state_e;

    // Default half-period divisor in system clock cycles.
    localparam int DEFAULT_HALF_DIV = 4;

    // An edge is a sample edge when it is odd-numbered and CPHA=0, or
    // even-numbered and CPHA=1. Every other edge is a launch edge.
    function automatic logic is_sample_edge(input logic odd_edge, input logic cpha);
        return odd_edge ^ cpha;
    endfunction

endpackage : spi_pkg

// File: rtl/spi_tick_divider.sv
// -----------------------------------------------------------------------------
// spi_tick_divider
//   Produces a single-cycle tick every 'period' clock cycles while enabled.
//   The count restarts from zero when 'restart' is high, so the first tick
//   after a restart arrives exactly 'period' cycles later. A period of zero
//   behaves like a period of one (tick every enabled cycle).
//
// Ports
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset, clears the counter
//   enable  : count and allow ticks
//   restart : clear the counter (takes priority over enable, suppresses tick)
//   period  : tick period in clk cycles
//   tick    : one-cycle pulse at the end of each period
// -----------------------------------------------------------------------------
module spi_tick_divider #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             restart,
    input  logic [DIV_W-1:0] period,
    output logic             tick
);

    localparam logic [DIV_W-1:0] DIV_ONE = 1;

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] last_count;
    logic             wrap;

    // Terminal count of the period; a zero period collapses to terminal 0.
    assign last_count = (period == '0) ? '0 : (period - DIV_ONE);

    // '>=' rather than '==' keeps the counter from running away should the
    // period ever shrink below the current count.
    assign wrap = (cnt_q >= last_count);

    assign tick = enable && !restart && wrap;

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = wrap ? '0 : (cnt_q + DIV_ONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : spi_tick_divider

// File: rtl/spi_sclk_engine.sv
// -----------------------------------------------------------------------------
// spi_sclk_engine
//   SPI master serial-clock and chip-select sequencer. One 'start' in IDLE
//   runs a frame of n_bits SCLK cycles:
//     LEAD (1 tick) -> CLOCKING (2*n_bits ticks, one SCLK edge each)
//     -> TRAIL (1 tick) -> IDLE with a one-cycle 'done'.
//   A tick is H system clocks, H being the half_div latched at start (0 -> 1),
//   so a frame keeps busy high for (2*n_bits+2)*H cycles.
//   launch_stb / sample_stb mark the data edges for the shift registers that
//   sit next to this block; both are registered alongside spi_sclk so that
//   they are high in the same cycle the new SCLK level appears.
//
// Parameters
//   DIV_W : width of half_div
//   CNT_W : width of n_bits and bit_index
//   CPOL  : idle level of spi_sclk
//   CPHA  : 0 = sample on leading edge, 1 = sample on trailing edge
//
// Ports
//   system_clock : clock, rising edge
//   reset        : asynchronous active-high reset
//   start        : begin a frame (accepted only in IDLE with n_bits != 0)
//   abort        : drop the frame in progress, back to IDLE without done
//   half_div     : SCLK half period in system_clock cycles
//   n_bits       : SCLK cycles per frame
//   spi_sclk     : serial clock
//   spi_cs_n     : active-low chip select
//   launch_stb   : pulse on each launch (shift-out) edge
//   sample_stb   : pulse on each sample (shift-in) edge
//   bit_index    : sample edges completed in the current frame
//   busy         : high outside IDLE
//   done         : pulse on normal frame completion
// -----------------------------------------------------------------------------
import spi_pkg::*;

module spi_sclk_engine #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 8,
    parameter int CPOL  = 0,
    parameter int CPHA  = 0
) (
    input  logic             system_clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [DIV_W-1:0] half_div,
    input  logic [CNT_W-1:0] n_bits,
    output logic             spi_sclk,
    output logic             spi_cs_n,
    output logic             launch_stb,
    output logic             sample_stb,
    output logic [CNT_W-1:0] bit_index,
    output logic             busy,
    output logic             done
);

    localparam logic             IDLE_LVL = (CPOL != 0);
    localparam logic             PHASE_1  = (CPHA != 0);
    localparam logic [DIV_W-1:0] DIV_ONE  = 1;
    localparam logic [CNT_W-1:0] BIT_ONE  = 1;
    localparam logic [CNT_W:0]   EDGE_ONE = 1;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    spi_state_e       state_q,  state_d;
    logic [DIV_W-1:0] hdiv_q,   hdiv_d;     // latched half period (>= 1)
    logic [CNT_W-1:0] nbits_q,  nbits_d;    // latched frame length
    logic [CNT_W:0]   edge_q,   edge_d;     // SCLK edges issued so far
    logic [CNT_W-1:0] bit_q,    bit_d;
    logic             sclk_q,   sclk_d;
    logic             launch_q, launch_d;
    logic             sample_q, sample_d;
    logic             done_q,   done_d;

    // Divider control
    logic             tick;
    logic             div_restart;
    logic             div_enable;

    // Edge classification for the tick being processed
    logic             odd_edge;
    logic             last_edge;
    logic             sample_edge;
    logic [CNT_W:0]   edge_inc;

    // ------------------------------------------------------------------
    // Tick generator
    // ------------------------------------------------------------------
    assign div_enable = (state_q != ST_IDLE);

    spi_tick_divider #(
        .DIV_W (DIV_W)
    ) u_tick_divider (
        .clk     (system_clock),
        .rst     (reset),
        .enable  (div_enable),
        .restart (div_restart),
        .period  (hdiv_q),
        .tick    (tick)
    );

    // edge_q counts completed edges, so the edge about to happen is
    // edge_q+1; it is odd-numbered when edge_q is even.
    assign edge_inc    = edge_q + EDGE_ONE;
    assign odd_edge    = ~edge_q[0];
    assign last_edge   = (edge_inc == {nbits_q, 1'b0});
    assign sample_edge = is_sample_edge(odd_edge, PHASE_1);

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        hdiv_d      = hdiv_q;
        nbits_d     = nbits_q;
        edge_d      = edge_q;
        sclk_d      = sclk_q;
        launch_d    = 1'b0;
        sample_d    = 1'b0;
        done_d      = 1'b0;
        div_restart = 1'b0;
        // The index follows the sample strobe by one cycle.
        bit_d       = sample_q ? (bit_q + BIT_ONE) : bit_q;

        unique case (state_q)
            ST_IDLE: begin
                // abort has no meaning here, so start wins if both are high.
                if (start && (n_bits != '0)) begin
                    state_d     = ST_LEAD;
                    hdiv_d      = (half_div == '0) ? DIV_ONE : half_div;
                    nbits_d     = n_bits;
                    edge_d      = '0;
                    bit_d       = '0;
                    sclk_d      = IDLE_LVL;
                    div_restart = 1'b1;
                    // CPHA=0 slaves sample on the very first edge, so the
                    // first bit has to be on the line before it.
                    launch_d    = ~PHASE_1;
                end
            end

            ST_LEAD: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    sclk_d      = IDLE_LVL;
                    div_restart = 1'b1;
                end else if (tick) begin
                    state_d = ST_CLOCKING;
                end
            end

            ST_CLOCKING: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    sclk_d      = IDLE_LVL;
                    div_restart = 1'b1;
                end else if (tick) begin
                    sclk_d   = ~sclk_q;
                    edge_d   = edge_inc;
                    sample_d = sample_edge;
                    launch_d = ~sample_edge;
                    // An even number of toggles leaves SCLK back at CPOL.
                    if (last_edge) begin
                        state_d = ST_TRAIL;
                    end
                end
            end

            ST_TRAIL: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    sclk_d      = IDLE_LVL;
                    div_restart = 1'b1;
                end else if (tick) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                sclk_d  = IDLE_LVL;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge system_clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            hdiv_q   <= DIV_ONE;
            nbits_q  <= '0;
            edge_q   <= '0;
            bit_q    <= '0;
            sclk_q   <= IDLE_LVL;
            launch_q <= 1'b0;
            sample_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hdiv_q   <= hdiv_d;
            nbits_q  <= nbits_d;
            edge_q   <= edge_d;
            bit_q    <= bit_d;
            sclk_q   <= sclk_d;
            launch_q <= launch_d;
            sample_q <= sample_d;
            done_q   <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign spi_sclk   = sclk_q;
    assign spi_cs_n   = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign launch_stb = launch_q;
    assign sample_stb = sample_q;
    assign bit_index  = bit_q;
    assign done       = done_q;

endmodule : spi_sclk_engine

// File: tb/tb_spi_sclk_engine.sv
// -----------------------------------------------------------------------------
// tb_spi_sclk_engine
//   Two engines share stimulus: index 0 is CPOL=0/CPHA=0, index 1 is
//   CPOL=1/CPHA=1. Every cycle of every frame is compared against a
//   cycle-offset model of the frame timing; a table of frames adds
//   per-frame totals, and hand sequences cover abort, reset and start corners.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_spi_sclk_engine;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] half_div;
    logic [7:0] n_bits;

    logic [1:0] sclk, cs_n, launch, sample, busy, done;
    logic [7:0] bidx0, bidx1;

    int errors = 0;
    int checks = 0;

    spi_sclk_engine #(.DIV_W(8), .CNT_W(8), .CPOL(0), .CPHA(0)) dut_a (
        .system_clock (clk),      .reset      (reset),
        .start        (start),    .abort      (abort),
        .half_div     (half_div), .n_bits     (n_bits),
        .spi_sclk     (sclk[0]),  .spi_cs_n   (cs_n[0]),
        .launch_stb   (launch[0]),.sample_stb (sample[0]),
        .bit_index    (bidx0),    .busy       (busy[0]),
        .done         (done[0])
    );

    spi_sclk_engine #(.DIV_W(8), .CNT_W(8), .CPOL(1), .CPHA(1)) dut_b (
        .system_clock (clk),      .reset      (reset),
        .start        (start),    .abort      (abort),
        .half_div     (half_div), .n_bits     (n_bits),
        .spi_sclk     (sclk[1]),  .spi_cs_n   (cs_n[1]),
        .launch_stb   (launch[1]),.sample_stb (sample[1]),
        .bit_index    (bidx1),    .busy       (busy[1]),
        .done         (done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       cs_n;
        logic       sclk;
        logic       launch;
        logic       sample;
        logic       done;
        logic [7:0] bit_idx;
    } obs_t;

    typedef struct {
        int h; int n; int abort_t; bit start_abort;
        int busy_cyc; int edges;
        int samp0; int samp1; int launch0; int launch1; int bit0; int bit1;
        int dones;
    } vec_t;

    // ---------------- reference model ----------------
    // Samples whose strobe cycle lies strictly before cycle t. Edge k's new
    // SCLK level (and its strobe) appears at frame cycle (k+1)*H.
    function automatic int samples_before(int t, int hh, int n, bit cpha);
        int c = 0;
        for (int k = 1; k <= 2 * n; k++) begin
            if ((((k % 2) == 1) != cpha) && ((k + 1) * hh < t)) c++;
        end
        return c;
    endfunction

    // Expected outputs at cycle t of a frame (t=0: first cycle after start
    // is accepted). abort_t < 0 means no abort.
    function automatic obs_t model(int t, int h, int n, int abort_t,
                                   bit cpol, bit cpha, int prev_bit);
        obs_t o;
        int hh, t_end, q, e, k;
        hh = (h == 0) ? 1 : h;
        o = '0;
        o.cs_n = 1'b1;
        o.sclk = cpol;
        o.bit_idx = 8'(prev_bit);
        if (n == 0) return o;
        t_end = (2 * n + 2) * hh;
        if (abort_t >= 0 && t > abort_t) begin
            o.bit_idx = 8'(samples_before(abort_t + 1, hh, n, cpha));
            return o;
        end
        o.bit_idx = 8'(samples_before(t, hh, n, cpha));
        if (t >= t_end) begin
            o.done = (t == t_end);
            return o;
        end
        o.busy = 1'b1;
        o.cs_n = 1'b0;
        q = t / hh;
        e = (q == 0) ? 0 : q - 1;
        o.sclk = cpol ^ ((e % 2) == 1);
        if ((t % hh) == 0 && q >= 2 && q <= 2 * n + 1) begin
            k = q - 1;
            if (((k % 2) == 1) != cpha) o.sample = 1'b1;
            else                        o.launch = 1'b1;
        end
        if (t == 0 && !cpha) o.launch = 1'b1;
        return o;
    endfunction

    function automatic obs_t get_obs(int d);
        obs_t o;
        o.busy    = busy[d];
        o.cs_n    = cs_n[d];
        o.sclk    = sclk[d];
        o.launch  = launch[d];
        o.sample  = sample[d];
        o.done    = done[d];
        o.bit_idx = (d == 0) ? bidx0 : bidx1;
        return o;
    endfunction

    task automatic check_obs(string name, int d, int t, obs_t exp);
        obs_t act;
        act = get_obs(d);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0d got {busy,cs_n,sclk,launch,sample,done}=%b bit=%0d required %b bit=%0d",
                     name, d, t, act[13:8], act.bit_idx, exp[13:8], exp.bit_idx);
        end
    endtask

    task automatic check_int(string name, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, got, want);
        end
    endtask

    // ---------------- frame driver ----------------
    int prev_bit [2];
    int c_busy [2], c_edges [2], c_samp [2], c_launch [2], c_done [2], last_bidx [2];

    // Called at a negedge with the engines idle. Returns at the negedge of
    // the cycle after 'done', so consecutive calls start back-to-back.
    task automatic run_frame(input int h, input int n, input int abort_t,
                             input bit start_abort, input bit rnd, input string tag);
        int hh, t_end, t_last, limit;
        logic [1:0] prev_s;
        obs_t exp;
        hh     = (h == 0) ? 1 : h;
        t_end  = (n != 0) ? (2 * n + 2) * hh : 0;
        t_last = (n != 0) ? t_end + 1 : 3;
        limit  = (abort_t >= 0) ? abort_t + 1 : t_end;
        for (int d = 0; d < 2; d++) begin
            c_busy[d] = 0; c_edges[d] = 0; c_samp[d] = 0; c_launch[d] = 0; c_done[d] = 0;
        end
        start    = 1'b1;
        abort    = start_abort;
        half_div = 8'(h);
        n_bits   = 8'(n);
        prev_s   = sclk;
        for (int t = 0; t <= t_last; t++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                exp = model(t, h, n, abort_t, d[0], d[0], prev_bit[d]);
                check_obs(tag, d, t, exp);
                if (busy[d]) c_busy[d]++;
                if (busy[d] && sclk[d] != prev_s[d]) c_edges[d]++;
                if (sample[d]) c_samp[d]++;
                if (launch[d]) c_launch[d]++;
                if (done[d]) c_done[d]++;
            end
            prev_s       = sclk;
            last_bidx[0] = bidx0;
            last_bidx[1] = bidx1;
            start = 1'b0;
            abort = (t == abort_t);
            // Junk on every input the engine must ignore while busy.
            if (rnd && t < limit) begin
                start    = 1'($urandom_range(0, 1));
                half_div = 8'($urandom);
                n_bits   = 8'($urandom);
            end
        end
        start = 1'b0;
        abort = 1'b0;
        for (int d = 0; d < 2; d++) begin
            exp = model(t_last, h, n, abort_t, d[0], d[0], prev_bit[d]);
            prev_bit[d] = int'(exp.bit_idx);
        end
    endtask

    vec_t vecs [7];

    initial begin
        obs_t rst_exp;
        int   t_a, sc, h, n, te, ab;

        // {h, n, abort_t, start_abort, busy, edges, samp0, samp1,
        //  launch0, launch1, bit0, bit1, dones}
        vecs[0] = '{3,  8, -1, 1'b0, 54, 16, 8, 8, 9, 8, 8, 8, 1};
        vecs[1] = '{1,  1, -1, 1'b0,  4,  2, 1, 1, 2, 1, 1, 1, 1};
        vecs[2] = '{0,  1, -1, 1'b0,  4,  2, 1, 1, 2, 1, 1, 1, 1};  // 0 acts as 1
        vecs[3] = '{2,  0, -1, 1'b0,  0,  0, 0, 0, 0, 0, 1, 1, 0};  // ignored
        vecs[4] = '{2, 16, 20, 1'b0, 21,  9, 5, 4, 5, 5, 5, 4, 0};  // abort at 5th sample (CPHA0)
        vecs[5] = '{5,  3, -1, 1'b1, 40,  6, 3, 3, 4, 3, 3, 3, 1};  // abort with start in IDLE
        vecs[6] = '{5,  3, -1, 1'b0, 40,  6, 3, 3, 4, 3, 3, 3, 1};  // back-to-back repeat

        start = 1'b0; abort = 1'b0; half_div = 8'd0; n_bits = 8'd0;
        reset = 1'b0;
        prev_bit[0] = 0; prev_bit[1] = 0;

        // Power-on reset, checked before any clock edge.
        #2 reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            rst_exp = '0; rst_exp.cs_n = 1'b1; rst_exp.sclk = d[0];
            check_obs("por_reset", d, -1, rst_exp);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // ---------------- table-driven frames ----------------
        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i].h, vecs[i].n, vecs[i].abort_t, vecs[i].start_abort, 1'b0,
                      $sformatf("vec%0d", i));
            for (int d = 0; d < 2; d++) begin
                check_int($sformatf("vec%0d_busy_d%0d", i, d),   c_busy[d],   vecs[i].busy_cyc);
                check_int($sformatf("vec%0d_edges_d%0d", i, d),  c_edges[d],  vecs[i].edges);
                check_int($sformatf("vec%0d_samp_d%0d", i, d),   c_samp[d],   (d == 0) ? vecs[i].samp0 : vecs[i].samp1);
                check_int($sformatf("vec%0d_launch_d%0d", i, d), c_launch[d], (d == 0) ? vecs[i].launch0 : vecs[i].launch1);
                check_int($sformatf("vec%0d_bitidx_d%0d", i, d), last_bidx[d], (d == 0) ? vecs[i].bit0 : vecs[i].bit1);
                check_int($sformatf("vec%0d_done_d%0d", i, d),   c_done[d],   vecs[i].dones);
            end
        end

        // ---------------- abort on the 5th sample strobe of engine 0 -------
        half_div = 8'd2; n_bits = 8'd16; start = 1'b1;
        t_a = -1; sc = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++)
                check_obs("abort_run", d, t, model(t, 2, 16, -1, d[0], d[0], prev_bit[d]));
            start = 1'b0;
            if (sample[0]) sc++;
            if (sc == 5) begin
                abort = 1'b1;
                t_a = t;
                break;
            end
        end
        if (t_a < 0) begin
            checks++; errors++;
            $display("FAIL abort_wait got=%0d samples required=5 within 200 cycles", sc);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end else begin
            check_int("abort_5th_sample_cycle", t_a, 20);
            for (int k = 1; k <= 3; k++) begin
                @(negedge clk);
                abort = 1'b0;
                if (k == 1) check_int("abort_cs_n_next", int'(cs_n[0]), 1);
                for (int d = 0; d < 2; d++)
                    check_obs("abort_after", d, t_a + k, model(t_a + k, 2, 16, t_a, d[0], d[0], prev_bit[d]));
            end
            for (int d = 0; d < 2; d++)
                prev_bit[d] = int'(model(t_a + 1, 2, 16, t_a, d[0], d[0], prev_bit[d]).bit_idx);
        end

        // ---------------- asynchronous reset mid-CLOCKING ----------------
        half_div = 8'd2; n_bits = 8'd4; start = 1'b1;
        for (int t = 0; t <= 6; t++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++)
                check_obs("reset_run", d, t, model(t, 2, 4, -1, d[0], d[0], prev_bit[d]));
            start = 1'b0;
        end
        #2 reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            rst_exp = '0; rst_exp.cs_n = 1'b1; rst_exp.sclk = d[0];
            check_obs("reset_async", d, 7, rst_exp);
        end
        @(negedge clk);
        reset = 1'b0;
        prev_bit[0] = 0; prev_bit[1] = 0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++)
                check_obs("post_reset_idle", d, t, model(t, 2, 0, -1, d[0], d[0], 0));
        end

        // ---------------- randomized frames ----------------
        for (int r = 0; r < 10; r++) begin
            h  = $urandom_range(0, 4);
            n  = $urandom_range(0, 6);
            te = (2 * n + 2) * ((h == 0) ? 1 : h);
            ab = -1;
            if (n != 0 && $urandom_range(0, 2) == 0) ab = $urandom_range(0, te - 1);
            run_frame(h, n, ab, 1'($urandom_range(0, 1)), 1'b1, $sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_spi_sclk_engine
